output_arbiter: RTL and testbench

- Per-output-port round-robin arbiter. One instance per router output port (5 per router), directly downstream of the request generation units.
- Bit i of rqs_in is bit j of input port i's rqs_vector, where j is this instance's output port.
- Grants the output port to one input, returns a one-cycle arb_ack pulse to the winner, and holds the crossbar select until the packet's tail has transferred.
- Drives the crossbar select for its output and the arb_ack inputs of the request generation units.

---
 rtl/output_arbiter_pkg.sv | 21 ++
 rtl/output_arbiter_rr_pick.sv | 38 +++
 rtl/output_arbiter.sv | 118 +++++++++++
 tb/tb_output_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/output_arbiter_pkg.sv
// Shared definitions for the router output-port arbiter.
//   PORTS        : number of router input ports (N, E, S, W, PE)
//   PORT_*       : input port index constants
//   arb_state_t  : arbiter FSM state encoding
package output_arbiter_pkg;

  localparam int PORTS = 5;

  localparam int PORT_N  = 0;
  localparam int PORT_E  = 1;
  localparam int PORT_S  = 2;
  localparam int PORT_W  = 3;
  localparam int PORT_PE = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_ACK  = 2'b01,
    ARB_HOLD = 2'b10
  } arb_state_t;

endpackage

// File: rtl/output_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans req starting at ptr, then ptr+1, ... modulo PORTS, and returns the
// first requester. Shared with the virtual-channel allocator.
//   req : request lines, bit i = requester i
//   ptr : highest-priority index (0..PORTS-1)
//   win : one-hot winner, all zeros when req is zero
//   idx : index of the winner (0 when req is zero)
module rr_pick #(
  parameter int PORTS = output_arbiter_pkg::PORTS,
  parameter int PW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic [PORTS-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PORTS-1:0] win,
  output logic [PW-1:0]    idx
);

  logic found;
  int   pos;

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < PORTS; k++) begin
      pos = (int'(ptr) + k) % PORTS;
      if (!found && req[pos]) begin
        win[pos] = 1'b1;
        idx      = PW'(pos);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_arbiter.sv
// Per-output-port round-robin arbiter.
// Grants the output to one requesting input, pulses ack_vector for one cycle
// to the winner and holds the crossbar select until the packet tail has
// crossed (xfer_done). The priority pointer advances past the winner only on
// release, so persistent requesters are served in rotated order.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   rqs_in       : bit i = input port i requests this output
//   out_ready    : downstream credit; new grants only while high
//   xfer_done    : one-cycle pulse when the granted packet's tail crosses
//   grant_vector : registered one-hot crossbar select, zero when free
//   ack_vector   : registered one-hot one-cycle acknowledge to the winner
//   busy         : output port allocated
module output_arbiter
  import output_arbiter_pkg::*;
#(
  parameter int PORTS   = output_arbiter_pkg::PORTS,
  parameter int PTR_RST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] rqs_in,
  input  logic             out_ready,
  input  logic             xfer_done,
  output logic [PORTS-1:0] grant_vector,
  output logic [PORTS-1:0] ack_vector,
  output logic             busy
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [PW-1:0] PTR_INIT = PW'(PTR_RST);

  arb_state_t       state, state_next;
  logic [PW-1:0]    ptr, ptr_next;
  logic [PW-1:0]    owner, owner_next;
  logic [PORTS-1:0] grant_next, ack_next;
  logic             busy_next;
  logic [PORTS-1:0] pick_win;
  logic [PW-1:0]    pick_idx;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    return (int'(i) == PORTS - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.PORTS(PORTS), .PW(PW)) u_pick (
    .req (rqs_in),
    .ptr (ptr),
    .win (pick_win),
    .idx (pick_idx)
  );

  always_comb begin
    state_next = state;
    grant_next = grant_vector;
    ack_next   = '0;
    busy_next  = busy;
    ptr_next   = ptr;
    owner_next = owner;
    case (state)
      ARB_IDLE: begin
        // xfer_done is meaningless here and deliberately ignored.
        if (out_ready && (rqs_in != '0)) begin
          state_next = ARB_ACK;
          grant_next = pick_win;
          ack_next   = pick_win;
          busy_next  = 1'b1;
          owner_next = pick_idx;
        end
      end
      ARB_ACK: begin
        // Single-flit packets can finish in the acknowledge cycle itself.
        if (xfer_done) begin
          state_next = ARB_IDLE;
          grant_next = '0;
          busy_next  = 1'b0;
          ptr_next   = wrap_inc(owner);
        end else begin
          state_next = ARB_HOLD;
        end
      end
      ARB_HOLD: begin
        // Requests and out_ready are ignored until the tail crosses.
        if (xfer_done) begin
          state_next = ARB_IDLE;
          grant_next = '0;
          busy_next  = 1'b0;
          ptr_next   = wrap_inc(owner);
        end
      end
      default: begin
        state_next = ARB_IDLE;
        grant_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ARB_IDLE;
      grant_vector <= '0;
      ack_vector   <= '0;
      busy         <= 1'b0;
      ptr          <= PTR_INIT;
      owner        <= '0;
    end else begin
      state        <= state_next;
      grant_vector <= grant_next;
      ack_vector   <= ack_next;
      busy         <= busy_next;
      ptr          <= ptr_next;
      owner        <= owner_next;
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter: directed scenarios followed by
// randomized traffic, all compared against a packet-level reference model.
module tb_output_arbiter;

  localparam int P       = 5;
  localparam int PTR_RST = 0;

  logic         clk;
  logic         rst;
  logic [P-1:0] rqs_in;
  logic         out_ready;
  logic         xfer_done;
  logic [P-1:0] grant_vector;
  logic [P-1:0] ack_vector;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port (-1 = free), whether this is the
  // acknowledge cycle, and the current highest-priority port.
  int m_owner;
  bit m_ack;
  int m_ptr;

  output_arbiter #(.PORTS(P), .PTR_RST(PTR_RST)) dut (
    .clk          (clk),
    .rst          (rst),
    .rqs_in       (rqs_in),
    .out_ready    (out_ready),
    .xfer_done    (xfer_done),
    .grant_vector (grant_vector),
    .ack_vector   (ack_vector),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [P-1:0] r, input int start);
    for (int k = 0; k < P; k++) begin
      if (r[(start + k) % P]) return (start + k) % P;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_ack   = 1'b0;
    m_ptr   = PTR_RST;
  endfunction

  function automatic void model_edge(input logic [P-1:0] r, input logic rdy, input logic d);
    if (m_owner < 0) begin
      if (rdy && r != '0) begin
        m_owner = first_from(r, m_ptr);
        m_ack   = 1'b1;
      end
    end else begin
      m_ack = 1'b0;
      if (d) begin
        m_ptr   = (m_owner + 1) % P;
        m_owner = -1;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    logic [P-1:0] eg;
    eg = (m_owner < 0) ? '0 : P'(1 << m_owner);
    check({tag, ".grant"}, 32'(grant_vector), 32'(eg));
    check({tag, ".ack"}, 32'(ack_vector), m_ack ? 32'(eg) : 32'd0);
    check({tag, ".busy"}, 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    check({tag, ".grant_onehot0"}, 32'($onehot0(grant_vector)), 32'd1);
    check({tag, ".ack_onehot0"}, 32'($onehot0(ack_vector)), 32'd1);
    check({tag, ".ack_eq_grant"},
          32'((ack_vector == '0) || (ack_vector == grant_vector)), 32'd1);
    check({tag, ".busy_eq_grant"}, 32'(busy), 32'(grant_vector != '0));
  endtask

  task automatic step(input string tag, input logic [P-1:0] r, input logic rdy, input logic d);
    rqs_in    = r;
    out_ready = rdy;
    xfer_done = d;
    @(posedge clk);
    model_edge(r, rdy, d);
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    #2;
    rst = 1'b1;
  endtask

  logic [P-1:0] rr_exp [4];

  initial begin
    rr_exp = '{5'b00001, 5'b00010, 5'b10000, 5'b00001};
    rst       = 1'b0;
    rqs_in    = 5'b11111;
    out_ready = 1'b1;
    xfer_done = 1'b0;
    model_reset();

    // Reset held with all requests active: nothing granted.
    repeat (2) begin
      @(posedge clk);
      #1;
      compare_all("reset");
    end
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    // The edge above already sampled the requests.
    model_edge(5'b11111, 1'b1, 1'b0);
    compare_all("reset_first");
    check("reset_first_grant", 32'(grant_vector), 32'b00001);
    step("reset_ack_drop", 5'b11111, 1'b1, 1'b0);
    check("ack_one_cycle", 32'(ack_vector), 32'd0);
    step("reset_release", 5'b11111, 1'b1, 1'b1);

    // Single-flit packet released in its acknowledge cycle.
    step("sf_idle", 5'b00000, 1'b1, 1'b0);
    step("sf_grant", 5'b00100, 1'b1, 1'b0);
    check("sf_grant_val", 32'(grant_vector), 32'b00100);
    step("sf_done", 5'b00100, 1'b1, 1'b1);
    check("sf_released", 32'(grant_vector), 32'd0);
    step("sf_ptr3", 5'b11111, 1'b1, 1'b0);
    check("sf_ptr3_val", 32'(grant_vector), 32'b01000);
    step("sf_hold", 5'b00000, 1'b0, 1'b0);
    step("sf_rel2", 5'b00000, 1'b0, 1'b1);

    // Wrap-around: pointer now 4, ports 0 and 3 requesting.
    step("wrap_grant", 5'b01001, 1'b1, 1'b0);
    check("wrap_val", 32'(grant_vector), 32'b00001);
    step("wrap_hold", 5'b01001, 1'b1, 1'b0);
    step("wrap_rel", 5'b01001, 1'b1, 1'b1);

    // Round-robin fairness from a fresh pointer.
    reset_pulse("rr_reset");
    for (int g = 0; g < 4; g++) begin
      step("rr_grant", 5'b10011, 1'b1, 1'b0);
      check("rr_order", 32'(grant_vector), 32'(rr_exp[g]));
      step("rr_h1", 5'b10011, 1'b1, 1'b0);
      step("rr_h2", 5'b10011, 1'b1, 1'b0);
      step("rr_done", 5'b10011, 1'b1, 1'b1);
    end

    // Backpressure, then hold while requests and credit drop.
    for (int i = 0; i < 4; i++) begin
      step("bp_wait", 5'b00010, 1'b0, 1'b0);
      check("bp_nogrant", 32'(grant_vector), 32'd0);
    end
    step("bp_grant", 5'b00010, 1'b1, 1'b0);
    check("bp_grant_val", 32'(grant_vector), 32'b00010);
    for (int i = 0; i < 3; i++) begin
      step("bp_hold", 5'b00000, 1'b0, 1'b0);
      check("bp_hold_val", 32'(grant_vector), 32'b00010);
    end
    step("bp_rel", 5'b00000, 1'b0, 1'b1);
    check("bp_rel_val", 32'(grant_vector), 32'd0);

    // Reset in the middle of a packet.
    step("mid_grant", 5'b01000, 1'b1, 1'b0);
    step("mid_hold", 5'b01000, 1'b1, 1'b0);
    check("mid_hold_val", 32'(grant_vector), 32'b01000);
    reset_pulse("mid_reset");
    step("mid_ptr_rst", 5'b11111, 1'b1, 1'b0);
    check("mid_ptr_rst_val", 32'(grant_vector), 32'b00001);
    step("mid_rel", 5'b11111, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      step("rand", P'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
